// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, oversampled mid-bit sampling, one-deep byte buffer.
// Frame is 8N1 by default; defining UART_RX_PARITY_EN adds an even-parity bit (8E1) and parity_err.
module uart_rx #(
    parameter int unsigned CLK_FREQ   = 25_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rx_read,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       rx_busy
);

    localparam int unsigned DIV = (CLK_FREQ + BAUD_RATE * OVERSAMPLE / 2) / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SW  = $clog2(OVERSAMPLE);

    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [SW-1:0] SAMP_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state;
    logic          sync1;
    logic          rxs;
    logic [TW-1:0] tick_cnt;
    logic [SW-1:0] samp_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          byte_done;
    logic          tick;
    logic          mid;
`ifdef UART_RX_PARITY_EN
    logic          par_bad;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rx;
            rxs   <= sync1;
        end
    end

    always_comb begin
        tick = (state != IDLE) && (tick_cnt == TICK_LAST);
        mid  = tick && (samp_cnt == SAMP_MID);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            samp_cnt  <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            byte_done <= 1'b0;
            rx_data   <= '0;
            rx_ready  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            rx_busy   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
            par_bad    <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            byte_done <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif

            // Counters held at zero in IDLE so the tick phase starts at start-bit detection
            if (state == IDLE) begin
                tick_cnt <= '0;
                samp_cnt <= '0;
            end else if (tick) begin
                tick_cnt <= '0;
                samp_cnt <= (samp_cnt == SAMP_LAST) ? '0 : samp_cnt + 1'b1;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state   <= START;
                        rx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (mid) begin
                        if (rxs) begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                            par_bad <= 1'b0;
`endif
                        end
                    end
                end
                DATA: begin
                    if (mid) begin
                        shift   <= {rxs, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (mid) begin
                        if (rxs != ^shift) begin
                            parity_err <= 1'b1;
                            par_bad    <= 1'b1;
                        end
                        state <= STOP;
                    end
                end
`endif
                // Back to IDLE at the stop-bit middle so a following start bit is not missed
                STOP: begin
                    if (mid) begin
                        if (rxs) begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            byte_done <= !par_bad;
`else
                            byte_done <= 1'b1;
`endif
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rxs) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase

            // A load in the same cycle as rx_read wins, leaving rx_ready set
            if (byte_done && (!rx_ready || rx_read)) begin
                rx_data  <= shift;
                rx_ready <= 1'b1;
            end else begin
                if (byte_done) begin
                    overrun <= 1'b1;
                end
                if (rx_read) begin
                    rx_ready <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames against a frame-level model.
// Runs at 6.4 MHz / 100 kbaud / x16 so a bit is 64 clocks and the whole run stays short.
module tb_uart_rx;

    localparam int unsigned CLK_FREQ = 6_400_000;
    localparam int unsigned BAUD     = 100_000;
    localparam int unsigned OS       = 16;
    localparam int unsigned DIV      = 4;        // round(6.4e6 / (100e3 * 16))
    localparam int unsigned BIT      = DIV * OS;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned FBITS = 11;
`else
    localparam int unsigned FBITS = 10;
`endif
    localparam int unsigned FRAME = FBITS * BIT;
    // pin fall -> rx_ready visible: 2 sync + 1 detect + half bit + bits up to stop middle + 1 load
    localparam int unsigned LAT = 3 + BIT / 2 + (FBITS - 1) * BIT + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx_read = 1'b0;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int total = 0;
    int bad = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int pe_cnt = 0;
    logic [7:0] last_good = 8'h00;

    uart_rx #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD_RATE(BAUD),
        .OVERSAMPLE(OS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .rx_read(rx_read),
        .rx_data(rx_data),
        .rx_ready(rx_ready),
        .frame_err(frame_err),
        .overrun(overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cnt++;
        if (overrun === 1'b1) ov_cnt++;
`ifdef UART_RX_PARITY_EN
        if (parity_err === 1'b1) pe_cnt++;
`endif
    end

    function automatic logic even_par(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return logic'(ones % 2);
    endfunction

    // Call at a negedge; drives a full frame, each bit held bclk clocks.
    task automatic send_frame(input logic [7:0] b, input int unsigned bclk, input logic par, input logic stop);
        rx = 1'b0;
        repeat (bclk) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (bclk) @(negedge clk);
        end
        if (FBITS == 11) begin
            rx = par;
            repeat (bclk) @(negedge clk);
        end
        rx = stop;
        repeat (bclk) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic wait_ready(input int unsigned budget, output int unsigned n, output bit seen);
        seen = 1'b0;
        n = 0;
        while (n < budget && !seen) begin
            @(negedge clk);
            n++;
            if (rx_ready === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic do_read();
        rx_read = 1'b1;
        @(negedge clk);
        rx_read = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({rx_data, rx_ready, frame_err, overrun, rx_busy} !== 12'h000) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=000", {rx_data, rx_ready, frame_err, overrun, rx_busy});
        end
        rst = 1'b0;
        repeat (10 * BIT) @(negedge clk);
        total++;
        if ({rx_data, rx_ready, rx_busy} !== 10'h000) begin
            bad++;
            $display("FAIL idle_outputs got=%h want=000", {rx_data, rx_ready, rx_busy});
        end
        total++;
        if (fe_cnt + ov_cnt + pe_cnt !== 0) begin
            bad++;
            $display("FAIL idle_pulses got=%0d want=0", fe_cnt + ov_cnt + pe_cnt);
        end
    endtask

    task automatic test_single_byte();
        int unsigned n;
        bit seen;
        send_frame(8'h41, BIT - 1, even_par(8'h41), 1'b1);
        wait_ready(2 * BIT, n, seen);
        total++;
        if (seen !== 1'b1 || rx_data !== 8'h41) begin
            bad++;
            $display("FAIL single_byte got=%h ready=%0b want=41", rx_data, seen);
        end
        last_good = 8'h41;
        do_read();
        total++;
        if (rx_ready !== 1'b0) begin
            bad++;
            $display("FAIL read_clears got=%0b want=0", rx_ready);
        end
    endtask

    task automatic test_overrun();
        int ov0 = ov_cnt;
        logic ov_at;
        fork
            begin
                send_frame(8'h55, BIT, even_par(8'h55), 1'b1);
                send_frame(8'hAA, BIT, even_par(8'hAA), 1'b1);
            end
            begin
                repeat (FRAME + LAT) @(negedge clk);
                ov_at = overrun;
            end
        join
        repeat (BIT) @(negedge clk);
        total++;
        if (ov_at !== 1'b1) begin
            bad++;
            $display("FAIL overrun_timing got=%0b want=1", ov_at);
        end
        total++;
        if (ov_cnt - ov0 !== 1) begin
            bad++;
            $display("FAIL overrun_count got=%0d want=1", ov_cnt - ov0);
        end
        total++;
        if (rx_data !== 8'h55 || rx_ready !== 1'b1) begin
            bad++;
            $display("FAIL overrun_keeps got=%h/%0b want=55/1", rx_data, rx_ready);
        end
        do_read();

        ov0 = ov_cnt;
        fork
            begin
                send_frame(8'h55, BIT, even_par(8'h55), 1'b1);
                send_frame(8'hAA, BIT, even_par(8'hAA), 1'b1);
            end
            begin
                repeat (FRAME + LAT - 1) @(negedge clk);
                rx_read = 1'b1;
                @(negedge clk);
                rx_read = 1'b0;
                total++;
                if (rx_ready !== 1'b1 || rx_data !== 8'hAA) begin
                    bad++;
                    $display("FAIL read_and_load got=%h/%0b want=aa/1", rx_data, rx_ready);
                end
            end
        join
        repeat (BIT) @(negedge clk);
        total++;
        if (ov_cnt - ov0 !== 0) begin
            bad++;
            $display("FAIL read_and_load_overrun got=%0d want=0", ov_cnt - ov0);
        end
        last_good = 8'hAA;
        do_read();
    endtask

    task automatic test_glitch_and_break();
        int fe0 = fe_cnt;
        int unsigned n;
        bit seen;
        rx = 1'b0;
        repeat (10) @(negedge clk);
        total++;
        if (rx_busy !== 1'b1) begin
            bad++;
            $display("FAIL glitch_busy got=%0b want=1", rx_busy);
        end
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (19) @(negedge clk);
        total++;
        if (rx_busy !== 1'b0 || rx_ready !== 1'b0 || fe_cnt != fe0) begin
            bad++;
            $display("FAIL glitch_reject got=busy%0b ready%0b fe%0d want=0/0/0", rx_busy, rx_ready, fe_cnt - fe0);
        end

        rx = 1'b0;
        repeat ((FBITS + 3) * BIT) @(negedge clk);
        total++;
        if (fe_cnt - fe0 !== 1 || rx_busy !== 1'b1 || rx_ready !== 1'b0) begin
            bad++;
            $display("FAIL break_hold got=fe%0d busy%0b ready%0b want=1/1/0", fe_cnt - fe0, rx_busy, rx_ready);
        end
        rx = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if (rx_busy !== 1'b0 || rx_data !== last_good) begin
            bad++;
            $display("FAIL break_release got=busy%0b data%h want=0/%h", rx_busy, rx_data, last_good);
        end
        send_frame(8'h5A, BIT, even_par(8'h5A), 1'b1);
        wait_ready(2 * BIT, n, seen);
        total++;
        if (seen !== 1'b1 || rx_data !== 8'h5A) begin
            bad++;
            $display("FAIL after_break got=%h ready=%0b want=5a", rx_data, seen);
        end
        last_good = 8'h5A;
        do_read();
    endtask

    task automatic test_loopback();
        int got = 0;
        int fe0 = fe_cnt;
        int ov0 = ov_cnt;
        int pe0 = pe_cnt;
        fork
            begin
                for (int c = 0; c < 26; c++) begin
                    send_frame(8'(8'h41 + c), BIT, even_par(8'(8'h41 + c)), 1'b1);
                end
            end
            begin
                int unsigned n = 0;
                logic [7:0] exp;
                while (got < 26 && n < 28 * FRAME) begin
                    @(negedge clk);
                    n++;
                    if (rx_ready === 1'b1) begin
                        exp = 8'(8'h41 + got);
                        total++;
                        if (rx_data !== exp) begin
                            bad++;
                            $display("FAIL loopback_byte%0d got=%h want=%h", got, rx_data, exp);
                        end
                        got++;
                        do_read();
                        n++;
                    end
                end
            end
        join
        last_good = 8'h5A;
        if (got > 0) last_good = 8'(8'h41 + got - 1);
        total++;
        if (got !== 26) begin
            bad++;
            $display("FAIL loopback_count got=%0d want=26", got);
        end
        total++;
        if ((fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0) !== 0) begin
            bad++;
            $display("FAIL loopback_errors got=%0d want=0", (fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0));
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 12; k++) begin
            logic [7:0] b = 8'($urandom);
            bit good = ($urandom_range(0, 3) != 0);
            int fe0 = fe_cnt;
            int unsigned n;
            bit seen;
            repeat ($urandom_range(4, BIT)) @(negedge clk);
            fork
                send_frame(b, BIT, even_par(b), logic'(good));
                wait_ready(LAT + BIT, n, seen);
            join
            if (good) begin
                total++;
                if (seen !== 1'b1 || n !== LAT || rx_data !== b) begin
                    bad++;
                    $display("FAIL random%0d got=%h lat=%0d ready=%0b want=%h lat=%0d", k, rx_data, n, seen, b, LAT);
                end
                last_good = b;
                do_read();
            end else begin
                total++;
                if (seen !== 1'b0 || fe_cnt - fe0 !== 1 || rx_data !== last_good) begin
                    bad++;
                    $display("FAIL random_frame%0d got=ready%0b fe%0d data%h want=0/1/%h", k, seen, fe_cnt - fe0, rx_data, last_good);
                end
            end
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int pe0 = pe_cnt;
        int unsigned n;
        bit seen;
        repeat (BIT) @(negedge clk);
        send_frame(8'h07, BIT, 1'b1, 1'b1);
        wait_ready(2 * BIT, n, seen);
        total++;
        if (seen !== 1'b1 || rx_data !== 8'h07 || pe_cnt != pe0) begin
            bad++;
            $display("FAIL parity_good got=%h ready=%0b pe=%0d want=07/1/0", rx_data, seen, pe_cnt - pe0);
        end
        last_good = 8'h07;
        do_read();
        fork
            send_frame(8'h07, BIT, 1'b0, 1'b1);
            wait_ready(LAT + BIT, n, seen);
        join
        total++;
        if (seen !== 1'b0 || pe_cnt - pe0 !== 1) begin
            bad++;
            $display("FAIL parity_bad got=ready%0b pe%0d want=0/1", seen, pe_cnt - pe0);
        end
    endtask
`endif

    task automatic test_reset_midbyte();
        fork
            send_frame(8'hC3, BIT, even_par(8'hC3), 1'b1);
            begin
                repeat (5 * BIT) @(negedge clk);
                #2 rst = 1'b1;
                #1;
                total++;
                if ({rx_data, rx_ready, frame_err, overrun, rx_busy} !== 12'h000) begin
                    bad++;
                    $display("FAIL async_reset got=%h want=000", {rx_data, rx_ready, frame_err, overrun, rx_busy});
                end
            end
        join
        repeat (BIT) @(negedge clk);
        rst = 1'b0;
        repeat (2 * FRAME) @(negedge clk);
        total++;
        if (rx_ready !== 1'b0 || rx_data !== 8'h00 || rx_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_byte got=%h/%0b/%0b want=00/0/0", rx_data, rx_ready, rx_busy);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_byte();
        test_overrun();
        test_glitch_and_break();
        test_loopback();
        test_random();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_reset_midbyte();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
